lector_7seg: RTL and testbench

LECTOR_7SEG -- requirements
Module: lector_7seg

---
 rtl/lector_7seg.sv | 189 ++++++++++++++++++
 tb/tb_lector_7seg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lector_7seg.sv
// lector_7seg: reads a multiplexed 4-digit 7-segment display bus and rebuilds
// the hex value being shown.
//
// The segment and anode buses are registered once, then each one-hot sample is
// decoded to a nibble. A digit is accepted only after ESTABLE consecutive
// identical samples of that digit; samples of other digits in between do not
// break the run.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   segmentos    - segment bus, active high, bit0=a .. bit6=g
//   anodos       - digit select, active high, bit i = digit i (digit 0 = LSD)
//   limpiar      - synchronous clear of all captured data
//   valor        - reconstructed value, digit i in bits [4i+3:4i]
//   valido       - high while all four digits are accepted
//   error        - one-cycle pulse on an illegal sample
//   cuenta_error - saturating count of error pulses
//                  (only when LECTOR_7SEG_CONTADOR_EN is defined)
//
// Build option: LECTOR_7SEG_CONTADOR_EN adds the cuenta_error counter/port.
//
// state     | meaning
// ----------+-----------------------------------
// ESPERA    | no digit accepted
// PARCIAL   | 1 to 3 digits accepted
// COMPLETO  | all four digits accepted (valido)

module lector_7seg #(
    parameter int ESTABLE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  segmentos,
    input  logic [3:0]  anodos,
    input  logic        limpiar,
    output logic [15:0] valor,
    output logic        valido,
    output logic        error
`ifdef LECTOR_7SEG_CONTADOR_EN
    ,
    output logic [7:0]  cuenta_error
`endif
);

    localparam logic [1:0] ESPERA   = 2'd0;
    localparam logic [1:0] PARCIAL  = 2'd1;
    localparam logic [1:0] COMPLETO = 2'd2;

    localparam logic [3:0] EST = 4'(ESTABLE);

    logic [6:0]  seg_r;
    logic [3:0]  an_r;
    logic [1:0]  estado;
    logic [1:0]  estado_n;
    logic [3:0]  aceptado;
    logic [3:0]  aceptado_n;
    logic [3:0]  cnt   [4];
    logic [3:0]  cnt_n [4];
    logic [3:0]  ult   [4];
    logic [3:0]  ult_n [4];
    logic [15:0] valor_n;
    logic [3:0]  nib;
    logic        legal;
    logic        one_hot;
    logic        multi;
    logic        error_n;

    always_comb begin
        nib   = 4'h0;
        legal = 1'b1;
        case (seg_r)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit set
    assign one_hot = (an_r != 4'h0) && ((an_r & (an_r - 4'h1)) == 4'h0);
    assign multi   = (an_r != 4'h0) && !one_hot;
    assign error_n = multi || (one_hot && !legal);

    always_comb begin
        cnt_n      = cnt;
        ult_n      = ult;
        valor_n    = valor;
        aceptado_n = aceptado;
        for (int i = 0; i < 4; i++) begin
            if (one_hot && an_r[i]) begin
                if (!legal) begin
                    cnt_n[i] = 4'd0;
                end else if (nib == ult[i]) begin
                    // a saturated counter stays put and never re-commits
                    if (cnt[i] < EST) begin
                        cnt_n[i] = cnt[i] + 4'd1;
                        if ((cnt[i] + 4'd1) == EST) begin
                            valor_n[4*i +: 4] = nib;
                            aceptado_n[i]     = 1'b1;
                        end
                    end
                end else begin
                    ult_n[i] = nib;
                    cnt_n[i] = 4'd1;
                    if (EST == 4'd1) begin
                        valor_n[4*i +: 4] = nib;
                        aceptado_n[i]     = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        if (aceptado_n == 4'h0)
            estado_n = ESPERA;
        else if (aceptado_n == 4'hF)
            estado_n = COMPLETO;
        else
            estado_n = PARCIAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r    <= 7'h00;
            an_r     <= 4'h0;
            valor    <= 16'h0000;
            aceptado <= 4'h0;
            estado   <= ESPERA;
            error    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 4'd0;
                ult[i] <= 4'd0;
            end
        end else begin
            seg_r <= segmentos;
            an_r  <= anodos;
            if (limpiar) begin
                // the sample processed this cycle is dropped, including any commit
                valor    <= 16'h0000;
                aceptado <= 4'h0;
                estado   <= ESPERA;
                error    <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    cnt[i] <= 4'd0;
                    ult[i] <= 4'd0;
                end
            end else begin
                valor    <= valor_n;
                aceptado <= aceptado_n;
                estado   <= estado_n;
                error    <= error_n;
                cnt      <= cnt_n;
                ult      <= ult_n;
            end
        end
    end

    assign valido = (estado == COMPLETO);

`ifdef LECTOR_7SEG_CONTADOR_EN
    // counts on the same edge that raises the error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cuenta_error <= 8'h00;
        else if (limpiar)
            cuenta_error <= 8'h00;
        else if (error_n && (cuenta_error != 8'hFF))
            cuenta_error <= cuenta_error + 8'h01;
    end
`else
    // no error counter in this build
`endif

endmodule

// File: tb/tb_lector_7seg.sv
module tb_lector_7seg;

    logic        clk;
    logic        rst_n;
    logic [6:0]  segmentos;
    logic [3:0]  anodos;
    logic        limpiar;
    logic [15:0] valor;
    logic        valido;
    logic        error;
`ifdef LECTOR_7SEG_CONTADOR_EN
    logic [7:0]  cuenta_error;
`endif

    int total = 0;
    int bad   = 0;

    lector_7seg #(.ESTABLE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .segmentos (segmentos),
        .anodos    (anodos),
        .limpiar   (limpiar),
        .valor     (valor),
        .valido    (valido),
        .error     (error)
`ifdef LECTOR_7SEG_CONTADOR_EN
        ,
        .cuenta_error (cuenta_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        lim;
        logic [15:0] valor;
        logic        valido;
        logic        err;
    } vec_t;

    vec_t tabla [18];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nombre, act, req);
        end
    endtask

    task automatic paso(input logic [6:0] s, input logic [3:0] a, input logic l);
        segmentos = s;
        anodos    = a;
        limpiar   = l;
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3);
        paso(d0, 4'b0001, 1'b0);
        paso(d1, 4'b0010, 1'b0);
        paso(d2, 4'b0100, 1'b0);
        paso(d3, 4'b1000, 1'b0);
    endtask

    initial begin
        // round-robin 1,2,3,4 for three scans, then error cases
        for (int s = 0; s < 3; s++) begin
            tabla[4*s+0] = '{7'h06, 4'b0001, 1'b0, 16'h0000, 1'b0, 1'b0};
            tabla[4*s+1] = '{7'h5B, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b0};
            tabla[4*s+2] = '{7'h4F, 4'b0100, 1'b0, 16'h0000, 1'b0, 1'b0};
            tabla[4*s+3] = '{7'h66, 4'b1000, 1'b0, 16'h0000, 1'b0, 1'b0};
        end
        tabla[9].valor  = 16'h0001;
        tabla[10].valor = 16'h0021;
        tabla[11].valor = 16'h0321;
        tabla[12] = '{7'h00, 4'b0000, 1'b0, 16'h4321, 1'b1, 1'b0};
        tabla[13] = '{7'h06, 4'b0011, 1'b0, 16'h4321, 1'b1, 1'b0};
        tabla[14] = '{7'h00, 4'b0000, 1'b0, 16'h4321, 1'b1, 1'b1};
        tabla[15] = '{7'h00, 4'b0100, 1'b0, 16'h4321, 1'b1, 1'b0};
        tabla[16] = '{7'h00, 4'b0000, 1'b0, 16'h4321, 1'b1, 1'b1};
        tabla[17] = '{7'h00, 4'b0000, 1'b0, 16'h4321, 1'b1, 1'b0};

        rst_n     = 1'b0;
        segmentos = 7'h00;
        anodos    = 4'h0;
        limpiar   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valor", 32'(valor), 32'h0);
        chk("reset valido", 32'(valido), 32'h0);
        chk("reset error", 32'(error), 32'h0);
        chk("reset estado", 32'(dut.estado), 32'h0);
`ifdef LECTOR_7SEG_CONTADOR_EN
        chk("reset cuenta_error", 32'(cuenta_error), 32'h0);
`endif
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) begin
            paso(tabla[k].seg, tabla[k].an, tabla[k].lim);
            chk($sformatf("tabla[%0d] valor", k), 32'(valor), 32'(tabla[k].valor));
            chk($sformatf("tabla[%0d] valido", k), 32'(valido), 32'(tabla[k].valido));
            chk($sformatf("tabla[%0d] error", k), 32'(error), 32'(tabla[k].err));
        end
        chk("illegal digit2 counter", 32'(dut.cnt[2]), 32'h0);

        // digit 0 alternates 8/9: never stable, value and valido hold
        for (int s = 0; s < 4; s++) begin
            scan((s % 2 == 0) ? 7'h7F : 7'h6F, 7'h5B, 7'h4F, 7'h66);
            chk($sformatf("alterna[%0d] valor", s), 32'(valor), 32'h4321);
            chk($sformatf("alterna[%0d] valido", s), 32'(valido), 32'h1);
        end
        // now hold 8: replaces digit 0 only on the third consecutive sample
        scan(7'h7F, 7'h5B, 7'h4F, 7'h66);
        scan(7'h7F, 7'h5B, 7'h4F, 7'h66);
        chk("nuevo digito antes", 32'(valor), 32'h4321);
        scan(7'h7F, 7'h5B, 7'h4F, 7'h66);
        chk("nuevo digito despues", 32'(valor), 32'h4328);
        chk("nuevo digito valido", 32'(valido), 32'h1);

        paso(7'h00, 4'b0000, 1'b1);
        chk("limpiar valor", 32'(valor), 32'h0);
        chk("limpiar valido", 32'(valido), 32'h0);
        chk("limpiar estado", 32'(dut.estado), 32'h0);

        // limpiar on the commit edge wins
        paso(7'h06, 4'b0001, 1'b0);
        paso(7'h06, 4'b0001, 1'b0);
        paso(7'h06, 4'b0001, 1'b0);
        paso(7'h00, 4'b0000, 1'b1);
        chk("limpiar prioridad valor", 32'(valor), 32'h0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("limpiar prioridad despues", 32'(valor), 32'h0);
        chk("limpiar prioridad estado", 32'(dut.estado), 32'h0);

        // digit 0 shows '0' for 3 edges; accepted only after the 4th
        paso(7'h3F, 4'b0001, 1'b0);
        paso(7'h3F, 4'b0001, 1'b0);
        paso(7'h3F, 4'b0001, 1'b0);
        chk("cero estado antes", 32'(dut.estado), 32'h0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("cero estado despues", 32'(dut.estado), 32'h1);
        chk("cero valor", 32'(valor), 32'h0);
        chk("cero valido", 32'(valido), 32'h0);

        paso(7'h07, 4'b0010, 1'b0);
        paso(7'h07, 4'b0010, 1'b0);
        paso(7'h07, 4'b0010, 1'b0);
        chk("latencia antes", 32'(valor), 32'h0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("latencia despues", 32'(valor), 32'h0070);

        // reset in the middle of a run on digit 2
        paso(7'h66, 4'b0100, 1'b0);
        paso(7'h66, 4'b0100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async valor", 32'(valor), 32'h0);
        chk("rst async valido", 32'(valido), 32'h0);
        chk("rst async estado", 32'(dut.estado), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        paso(7'h66, 4'b0100, 1'b0);
        paso(7'h00, 4'b0000, 1'b0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("rst descarta racha", 32'(valor), 32'h0);
        paso(7'h66, 4'b0100, 1'b0);
        paso(7'h66, 4'b0100, 1'b0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("rst nueva racha", 32'(valor), 32'h0400);
        chk("rst nueva estado", 32'(dut.estado), 32'h1);

`ifdef LECTOR_7SEG_CONTADOR_EN
        for (int n = 0; n < 300; n++)
            paso(7'h06, 4'b0011, 1'b0);
        paso(7'h00, 4'b0000, 1'b0);
        chk("cuenta_error saturada", 32'(cuenta_error), 32'hFF);
        paso(7'h00, 4'b0000, 1'b1);
        chk("cuenta_error limpiar", 32'(cuenta_error), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
